// File: rtl/tdm_demux4.sv
// tdm_demux4 -- four-channel time-division demultiplexer.
//
// A single serial lane carries repeating four-slot frames, slot 0 marked by
// a sync strobe. Slots 0..2 are captured into staging registers. The slot-3
// beat publishes all four channel words together on the same edge, so
// consumers never see a partially updated frame.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   din          serial data lane, one slot per accepted beat
//   din_valid    beat qualifier; din and sync are sampled only when high
//   sync         marks the current beat as slot 0 of a frame
//   ch0..ch3     channel words from the last complete frame
//   frame_valid  one-cycle pulse: ch0..ch3 have just been updated
//   locked       high while the framer is in LOCKED
//   slot         slot index expected on the next accepted beat
//   sync_err     one-cycle pulse on a framing violation
module tdm_demux4 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   input  logic         din_valid,
   input  logic         sync,
   output logic [W-1:0] ch0,
   output logic [W-1:0] ch1,
   output logic [W-1:0] ch2,
   output logic [W-1:0] ch3,
   output logic         frame_valid,
   output logic         locked,
   output logic [1:0]   slot,
   output logic         sync_err
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t       state_q, state_d;
   logic [1:0]   slot_q, slot_d;
   // Slot 3 is never staged: it is routed straight to ch3 on publish.
   logic [W-1:0] stg_q [3];
   logic [W-1:0] stg_d [3];
   logic [W-1:0] ch_q  [4];
   logic [W-1:0] ch_d  [4];
   logic         frame_valid_q, frame_valid_d;
   logic         sync_err_q, sync_err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= HUNT;
         slot_q        <= 2'd0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
         for (int i = 0; i < 3; i++) stg_q[i] <= '0;
         for (int i = 0; i < 4; i++) ch_q[i]  <= '0;
      end else begin
         state_q       <= state_d;
         slot_q        <= slot_d;
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
         for (int i = 0; i < 3; i++) stg_q[i] <= stg_d[i];
         for (int i = 0; i < 4; i++) ch_q[i]  <= ch_d[i];
      end
   end

   always_comb begin
      state_d       = state_q;
      slot_d        = slot_q;
      frame_valid_d = 1'b0;
      sync_err_d    = 1'b0;
      for (int i = 0; i < 3; i++) stg_d[i] = stg_q[i];
      for (int i = 0; i < 4; i++) ch_d[i]  = ch_q[i];

      if (din_valid) begin
         case (state_q)
            HUNT: begin
               // Non-sync beats while hunting are silently dropped.
               if (sync) begin
                  stg_d[0] = din;
                  slot_d   = 2'd1;
                  state_d  = LOCKED;
               end
            end

            LOCKED: begin
               if (sync) begin
                  // Sync anywhere but slot 0 is an early resync: flag it and
                  // restart the frame with this beat. Stale staging in slots
                  // 1..2 is overwritten before it can ever be published.
                  sync_err_d = (slot_q != 2'd0);
                  stg_d[0]   = din;
                  slot_d     = 2'd1;
               end else begin
                  case (slot_q)
                     2'd0: begin
                        // Expected a sync strobe here: framing is lost.
                        sync_err_d = 1'b1;
                        slot_d     = 2'd0;
                        state_d    = HUNT;
                     end
                     2'd1: begin
                        stg_d[1] = din;
                        slot_d   = 2'd2;
                     end
                     2'd2: begin
                        stg_d[2] = din;
                        slot_d   = 2'd3;
                     end
                     default: begin
                        // Slot 3 completes the frame: publish atomically.
                        ch_d[0]       = stg_q[0];
                        ch_d[1]       = stg_q[1];
                        ch_d[2]       = stg_q[2];
                        ch_d[3]       = din;
                        frame_valid_d = 1'b1;
                        slot_d        = 2'd0;
                     end
                  endcase
               end
            end

            default: begin
               state_d = HUNT;
               slot_d  = 2'd0;
            end
         endcase
      end
   end

   assign ch0         = ch_q[0];
   assign ch1         = ch_q[1];
   assign ch2         = ch_q[2];
   assign ch3         = ch_q[3];
   assign frame_valid = frame_valid_q;
   assign sync_err    = sync_err_q;
   assign locked      = (state_q == LOCKED);
   assign slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4 -- self-checking bench for tdm_demux4.
//
// Stimulus pushes the expected event (published frame or framing error)
// into a queue; a monitor on the falling edge pops and compares whenever
// the DUT pulses frame_valid or sync_err. Static state (locked, slot,
// held channel values, reset values) is checked directly after each beat.
module tb_tdm_demux4;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] din;
   logic         din_valid;
   logic         sync;
   logic [W-1:0] ch0, ch1, ch2, ch3;
   logic         frame_valid;
   logic         locked;
   logic [1:0]   slot;
   logic         sync_err;

   tdm_demux4 #(.W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .sync        (sync),
      .ch0         (ch0),
      .ch1         (ch1),
      .ch2         (ch2),
      .ch3         (ch3),
      .frame_valid (frame_valid),
      .locked      (locked),
      .slot        (slot),
      .sync_err    (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_err;
      logic [31:0] ch;
   } event_t;

   event_t      exp_q [$];
   event_t      mon_e;
   logic [31:0] exp_ch;
   int          tests = 0;
   int          fails = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // Expected frame publish; also updates the model of held channel words.
   task automatic expect_frame(input logic [31:0] chs);
      event_t e;
      e.is_err = 1'b0;
      e.ch     = chs;
      exp_ch   = chs;
      exp_q.push_back(e);
   endtask

   // Expected framing error; channel words must still hold.
   task automatic expect_err();
      event_t e;
      e.is_err = 1'b1;
      e.ch     = exp_ch;
      exp_q.push_back(e);
   endtask

   task automatic beat(input logic [W-1:0] d, input logic s);
      din       = d;
      sync      = s;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         din  = W'($urandom);
         sync = 1'($urandom);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_state(string tag, logic exp_locked, logic [1:0] exp_slot);
      check({tag, "_locked"}, 32'(locked), 32'(exp_locked));
      check({tag, "_slot"},   32'(slot),   32'(exp_slot));
   endtask

   function automatic logic [31:0] cur_ch();
      return {ch0, ch1, ch2, ch3};
   endfunction

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (rst_n && (frame_valid || sync_err)) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got fv=%b se=%b, expected no event",
                     frame_valid, sync_err);
         end else begin
            mon_e = exp_q.pop_front();
            check("event_kind", 32'({frame_valid, sync_err}),
                  mon_e.is_err ? 32'd1 : 32'd2);
            check("event_ch", cur_ch(), mon_e.ch);
            $display("[TB] %s ch=%08h fv=%b se=%b", mon_e.is_err ? "sync_err" : "frame   ",
                     cur_ch(), frame_valid, sync_err);
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      din       = '0;
      din_valid = 1'b0;
      sync      = 1'b0;
      exp_ch    = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      // Reset values
      check("rst_ch", cur_ch(), 32'h0);
      check("rst_fv", 32'(frame_valid), 32'd0);
      check("rst_se", 32'(sync_err), 32'd0);
      check_state("rst", 1'b0, 2'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic frame
      expect_frame(32'h11223344);
      beat(8'h11, 1'b1);
      check_state("basic_s1", 1'b1, 2'd1);
      beat(8'h22, 1'b0);
      beat(8'h33, 1'b0);
      check("basic_hold", cur_ch(), 32'h0);
      beat(8'h44, 1'b0);
      check("basic_ch", cur_ch(), 32'h11223344);
      check_state("basic_end", 1'b1, 2'd0);
      gap(2);
      check("basic_fv_one_cycle", 32'(frame_valid), 32'd0);

      // Gapped beats with noisy gap data
      expect_frame(32'h11223344);
      beat(8'h11, 1'b1);
      gap(2);
      check_state("gap_s1", 1'b1, 2'd1);
      beat(8'h22, 1'b0);
      gap(2);
      beat(8'h33, 1'b0);
      gap(2);
      check_state("gap_s3", 1'b1, 2'd3);
      beat(8'h44, 1'b0);
      gap(2);
      check("gap_ch", cur_ch(), 32'h11223344);

      // Reset asserted mid-frame
      beat(8'h5A, 1'b1);
      beat(8'h5B, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_ch", cur_ch(), 32'h0);
      check_state("midrst", 1'b0, 2'd0);
      exp_ch = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Hunt discard
      beat(8'hAA, 1'b0);
      beat(8'hBB, 1'b0);
      check_state("hunt", 1'b0, 2'd0);
      expect_frame(32'h01020304);
      beat(8'h01, 1'b1);
      beat(8'h02, 1'b0);
      beat(8'h03, 1'b0);
      beat(8'h04, 1'b0);
      check("hunt_ch", cur_ch(), 32'h01020304);

      // Early sync
      beat(8'h55, 1'b1);
      beat(8'h66, 1'b0);
      expect_err();
      beat(8'h77, 1'b1);
      check_state("early", 1'b1, 2'd1);
      check("early_hold", cur_ch(), 32'h01020304);
      expect_frame(32'h778899AA);
      beat(8'h88, 1'b0);
      beat(8'h99, 1'b0);
      beat(8'hAA, 1'b0);
      check("early_ch", cur_ch(), 32'h778899AA);

      // Lost sync, then relock
      expect_err();
      beat(8'hEE, 1'b0);
      check_state("lost", 1'b0, 2'd0);
      check("lost_hold", cur_ch(), 32'h778899AA);
      expect_frame(32'hC1C2C3C4);
      beat(8'hC1, 1'b1);
      check_state("relock", 1'b1, 2'd1);
      beat(8'hC2, 1'b0);
      beat(8'hC3, 1'b0);
      beat(8'hC4, 1'b0);
      check("relock_ch", cur_ch(), 32'hC1C2C3C4);

      gap(3);
      check("pending_events", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
